// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage mul/div request, MTHI/MTLO write and HI/LO result bundle.
interface ex_muldiv_if;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        stallreq;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output flush, start, op, src_a, src_b, hi_we, lo_we, hilo_wdata,
                    input  stallreq, busy, done, hi, lo);
    modport slave  (input  flush, start, op, src_a, src_b, hi_we, lo_we, hilo_wdata,
                    output stallreq, busy, done, hi, lo);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv (
    input logic         clk,
    input logic         rst,
    ex_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nx;
    logic        div_q, neg_q, rneg_q;
    logic [31:0] a_q, b_q, raw_a;
    logic [4:0]  cnt;
    logic [63:0] acc, acc_nx, prod;
    logic [32:0] sum, rem_sh, diff;
    logic [31:0] quo, rem, mag_a, mag_b;
    logic        sx, go, fin, fast;
    assign sx     = ~bus.op[0];
    assign mag_a  = (sx & bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign mag_b  = (sx & bus.src_b[31]) ? -bus.src_b : bus.src_b;
    assign go     = state == IDLE && bus.start && !bus.flush;
    assign fin    = state == CALC && cnt == 5'd31 && !bus.flush;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_p;
    assign fast   = go & ~bus.op[1];
    // Sign-extended 64-bit product truncated to 64 bits gives the signed result too
    assign fast_p = {{32{sx & bus.src_a[31]}}, bus.src_a} * {{32{sx & bus.src_b[31]}}, bus.src_b};
`else
    assign fast   = 1'b0;
`endif
    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    assign sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
    assign rem_sh = acc[63:31];
    assign diff   = rem_sh - {1'b0, b_q};
    assign acc_nx = div_q ? {diff[32] ? rem_sh[31:0] : diff[31:0], acc[30:0], ~diff[32]}
                          : {sum, acc[31:1]};
    assign prod   = neg_q ? -acc_nx : acc_nx;
    assign quo    = neg_q ? -acc_nx[31:0] : acc_nx[31:0];
    assign rem    = rneg_q ? -acc_nx[63:32] : acc_nx[63:32];
    always_comb begin
        state_nx = bus.flush ? IDLE
                 : state == IDLE ? (bus.start ? (fast ? DONE : CALC) : IDLE)
                 : state == CALC ? (cnt == 5'd31 ? DONE : CALC)
                 : IDLE;
    end
    assign bus.stallreq = rst && ((state == IDLE && bus.start && !bus.flush) || state == CALC);
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE && !bus.flush;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            raw_a  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == CALC && !bus.flush) ? cnt + 5'd1 : 5'd0;
            if (go) begin
                div_q  <= bus.op[1];
                a_q    <= mag_a;
                b_q    <= mag_b;
                raw_a  <= bus.src_a;
                neg_q  <= sx & (bus.src_a[31] ^ bus.src_b[31]);
                rneg_q <= sx & bus.src_a[31];
                acc    <= {32'd0, bus.op[1] ? mag_a : mag_b};
            end else if (state == CALC) begin
                acc <= acc_nx;
            end
            if (fin) begin
                bus.hi <= !div_q ? prod[63:32] : b_q == 32'd0 ? raw_a : rem;
                bus.lo <= !div_q ? prod[31:0] : b_q == 32'd0 ? 32'hFFFF_FFFF : quo;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast) begin
                bus.hi <= fast_p[63:32];
                bus.lo <= fast_p[31:0];
            end
`endif
            else if (state == IDLE && !bus.start && !bus.flush) begin
                if (bus.hi_we) bus.hi <= bus.hilo_wdata;
                if (bus.lo_we) bus.lo <= bus.hilo_wdata;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and random checks of ex_muldiv against an arithmetic reference.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ex_muldiv_if bus();
    ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: return b == 0 ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int stalls, done_at, exp_cyc;
        e = model(o, a, b);
`ifdef MULDIV_FAST_MUL_EN
        exp_cyc = o[1] ? 33 : 1;
`else
        exp_cyc = 33;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        stalls    = 0;
        done_at   = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.stallreq) stalls++;
            if (k == 16) chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
            if (bus.done) begin
                done_at = k;
                break;
            end
        end
        chk({tag, ".stall"}, 64'(stalls), 64'(exp_cyc));
        chk({tag, ".done_at"}, 64'(done_at), 64'(exp_cyc));
        chk({tag, ".hi"}, 64'(bus.hi), 64'(e[63:32]));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(e[31:0]));
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        bus.flush = 1'b0; bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hilo_wdata = '0;
        // Reset held with random inputs
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'($urandom); bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
            bus.hi_we = 1'($urandom); bus.lo_we = 1'($urandom); bus.hilo_wdata = $urandom;
            bus.flush = 1'($urandom);
        end
        #1;
        chk("rst.hi", 64'(bus.hi), 64'd0);
        chk("rst.lo", 64'(bus.lo), 64'd0);
        chk("rst.stallreq", 64'(bus.stallreq), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rel.busy", 64'(bus.busy), 64'd0);
        chk("rel.stallreq", 64'(bus.stallreq), 64'd0);
        chk("rel.hi", 64'(bus.hi), 64'd0);
        // Directed cases, issued back-to-back
        do_op("multu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5);
        do_op("divu_100_7", 2'd3, 32'd100, 32'd7);
        do_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_by0", 2'd3, 32'h0000_1234, 32'd0);
        do_op("div_by0", 2'd2, 32'h8000_0001, 32'd0);
        do_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000);
        // Random operations with forced corner operands
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) b = 32'd0;
            if (i % 6 == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i % 6 == 2) b = $urandom_range(1, 15);
            do_op($sformatf("rnd%0d_op%0d", i, o), o, a, b);
        end
        @(negedge clk);
        bus.start = 1'b0;
        // MTHI / MTLO in IDLE
        @(negedge clk);
        bus.hi_we = 1'b1; bus.hilo_wdata = 32'hAAAA_0000;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h0000_5555;
        @(negedge clk);
        bus.lo_we = 1'b0;
        #1;
        chk("mthi", 64'(bus.hi), 64'hAAAA_0000);
        chk("mtlo", 64'(bus.lo), 64'h0000_5555);
        // Flush at CALC cycle 10 keeps HI/LO and emits no done
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush.busy", 64'(bus.busy), 64'd0);
        chk("flush.stallreq", 64'(bus.stallreq), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("flush.done%0d", k), 64'(bus.done), 64'd0);
            chk($sformatf("flush.hi%0d", k), 64'(bus.hi), 64'hAAAA_0000);
            chk($sformatf("flush.lo%0d", k), 64'(bus.lo), 64'h0000_5555);
            @(negedge clk); #1;
        end
        // Asynchronous reset at CALC cycle 5
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd77; bus.src_b = 32'd5;
        repeat (6) @(negedge clk);
        #1;
        chk("arst.pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst.hi", 64'(bus.hi), 64'd0);
        chk("arst.lo", 64'(bus.lo), 64'd0);
        chk("arst.busy", 64'(bus.busy), 64'd0);
        chk("arst.stallreq", 64'(bus.stallreq), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("arst.idle", 64'(bus.busy), 64'd0);
        do_op("post_rst", 2'd3, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
